// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: 3-cycle request-to-response latency with zero-wait slaves.
// All AXI valids and resp_valid are held until their handshake; req_ready is low outside IDLE.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,

  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,

  output logic [ADDR_W-1:0]   axi_araddr,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  output logic [2:0]          axi_arprot,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready,

  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [2:0]          axi_awprot,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state;

  // AW and W retire independently; a channel counts as done once its valid is low
  // or its handshake is happening this edge.
  logic aw_hs, w_hs, aw_done, w_done;
  assign aw_hs   = axi_awvalid & axi_awready;
  assign w_hs    = axi_wvalid  & axi_wready;
  assign aw_done = ~axi_awvalid | axi_awready;
  assign w_done  = ~axi_wvalid  | axi_wready;

  assign axi_arprot = 3'b000;
  assign axi_awprot = 3'b000;

  // Only resp[1] distinguishes error from OKAY/EXOKAY.
  logic unused_resp_lsb;
  assign unused_resp_lsb = axi_rresp[0] ^ axi_bresp[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (req_we) begin
              axi_awaddr  <= req_addr;
              axi_wdata   <= req_wdata;
              axi_wstrb   <= req_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= WREQ;
            end else begin
              axi_araddr  <= req_addr;
              axi_arvalid <= 1'b1;
              state       <= RADDR;
            end
          end
        end

        RADDR: begin
          if (axi_arvalid && axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RDATA;
          end
        end

        RDATA: begin
          if (axi_rvalid && axi_rready) begin
            resp_rdata <= axi_rdata;
            resp_err   <= axi_rresp[1];
            axi_rready <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        WREQ: begin
          if (aw_hs) axi_awvalid <= 1'b0;
          if (w_hs)  axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            axi_bready <= 1'b1;
            state      <= WRESP;
          end
        end

        WRESP: begin
          if (axi_bvalid && axi_bready) begin
            axi_bready <= 1'b0;
            resp_err   <= axi_bresp[1];
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
